// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller side (master) reads the IR and memory handshake and drives every select/enable.
interface multicycle_ctrl_if;
  logic [31:0] Instruction;
  logic        mem_ready;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRwrite;
  logic        RegWrite;
  logic        ALUsrcA;
  logic        PCwrite;
  logic        PCwriteCond;
  logic        BranchNe;
  logic        ExtOp;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic [1:0]  ALUsrcB;
  logic [2:0]  ALUop;
  logic [1:0]  PCsource;
  logic        instr_done;
  logic        illegal;
  logic [3:0]  state_o;

  modport master (
    input  Instruction, mem_ready,
    output IorD, MemRead, MemWrite, IRwrite, RegWrite, ALUsrcA, PCwrite, PCwriteCond,
           BranchNe, ExtOp, RegDst, MemtoReg, ALUsrcB, ALUop, PCsource, instr_done,
           illegal, state_o
  );

  modport slave (
    output Instruction, mem_ready,
    input  IorD, MemRead, MemWrite, IRwrite, RegWrite, ALUsrcA, PCwrite, PCwriteCond,
           BranchNe, ExtOp, RegDst, MemtoReg, ALUsrcB, ALUop, PCsource, instr_done,
           illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style multi-cycle MIPS control unit: decodes the state register into datapath selects
// and write enables, with optional memory wait states and an illegal-opcode trap.
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StIExec   = 4'd10,
    StIWb     = 4'd11,
    StJal     = 4'd12,
    StJr      = 4'd13,
    StTrap    = 4'd15
  } ctrlState;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] FnJr    = 6'b001000;

  ctrlState   stateQ, stateD;
  logic [5:0] op, funct;
  logic       memRdy;
  logic       unusedInstr;

  assign op          = bus.Instruction[31:26];
  assign funct       = bus.Instruction[5:0];
  assign unusedInstr = ^bus.Instruction[25:6];
  // Without the handshake every memory access completes in one cycle.
  assign memRdy      = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= StFetch;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StFetch:   if (memRdy) stateD = StDecode;
      StDecode: begin
        case (op)
          OpRtype:                      stateD = (funct == FnJr) ? StJr : StRExec;
          OpLw, OpSw:                   stateD = StMemAddr;
          OpBeq, OpBne:                 stateD = StBranch;
          OpJ:                          stateD = StJump;
          OpJal:                        stateD = StJal;
          OpAddi, OpSlti, OpAndi, OpOri: stateD = StIExec;
          default:                      stateD = StTrap;
        endcase
      end
      StMemAddr: stateD = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (memRdy) stateD = StMemWb;
      StMemWr:   if (memRdy) stateD = StFetch;
      StRExec:   stateD = StRWb;
      StIExec:   stateD = StIWb;
      StMemWb, StRWb, StBranch, StJump, StJal, StJr, StIWb: stateD = StFetch;
      StTrap:    stateD = HALT_ON_ILLEGAL ? StTrap : StFetch;
      default:   stateD = StTrap;
    endcase
  end

  // Outputs are held at zero for the whole reset, even though the state already reads FETCH.
  always_comb begin
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRwrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUsrcA     = 1'b0;
    bus.PCwrite     = 1'b0;
    bus.PCwriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.ExtOp       = 1'b0;
    bus.RegDst      = 2'b00;
    bus.MemtoReg    = 2'b00;
    bus.ALUsrcB     = 2'b00;
    bus.ALUop       = 3'b000;
    bus.PCsource    = 2'b00;
    bus.instr_done  = 1'b0;
    bus.illegal     = 1'b0;
    bus.state_o     = 4'd0;
    if (rst_n) begin
      bus.state_o = stateQ;
      case (stateQ)
        StFetch: begin
          bus.MemRead = 1'b1;
          bus.ALUsrcB = 2'b01;
          bus.IRwrite = memRdy;
          bus.PCwrite = memRdy;
        end
        StDecode: begin
          bus.ALUsrcB = 2'b11;
          bus.ExtOp   = 1'b1;
        end
        StMemAddr: begin
          bus.ALUsrcA = 1'b1;
          bus.ALUsrcB = 2'b10;
          bus.ExtOp   = 1'b1;
        end
        StMemRd: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        StMemWb: begin
          bus.RegWrite   = 1'b1;
          bus.MemtoReg   = 2'b01;
          bus.instr_done = 1'b1;
        end
        StMemWr: begin
          bus.IorD       = 1'b1;
          bus.MemWrite   = memRdy;
          bus.instr_done = memRdy;
        end
        StRExec: begin
          bus.ALUsrcA = 1'b1;
          bus.ALUop   = 3'b010;
        end
        StRWb: begin
          bus.RegWrite   = 1'b1;
          bus.RegDst     = 2'b01;
          bus.instr_done = 1'b1;
        end
        StBranch: begin
          bus.ALUsrcA     = 1'b1;
          bus.ALUop       = 3'b001;
          bus.PCsource    = 2'b01;
          bus.PCwriteCond = 1'b1;
          bus.BranchNe    = op[0];
          bus.instr_done  = 1'b1;
        end
        StJump: begin
          bus.PCsource   = 2'b10;
          bus.PCwrite    = 1'b1;
          bus.instr_done = 1'b1;
        end
        StJal: begin
          bus.PCsource   = 2'b10;
          bus.PCwrite    = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.RegDst     = 2'b10;
          bus.MemtoReg   = 2'b10;
          bus.instr_done = 1'b1;
        end
        StJr: begin
          bus.PCsource   = 2'b11;
          bus.PCwrite    = 1'b1;
          bus.instr_done = 1'b1;
        end
        StIExec: begin
          bus.ALUsrcA = 1'b1;
          bus.ALUsrcB = 2'b10;
          case (op)
            OpSlti:  bus.ALUop = 3'b101;
            OpAndi:  bus.ALUop = 3'b011;
            OpOri:   bus.ALUop = 3'b100;
            default: bus.ALUop = 3'b000;
          endcase
          bus.ExtOp = (op == OpAddi) || (op == OpSlti);
        end
        StIWb: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        StTrap:  bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: two instances (handshake+halt, and neither) driven
// from vector tables through an expected-output scoreboard, plus hand-written reset sequences.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if busA ();
  multicycle_ctrl_if busB ();

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .HALT_ON_ILLEGAL(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA)
  );
  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .HALT_ON_ILLEGAL(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB)
  );

  // Observed outputs packed into one word, laid out to match the E* constants below.
  logic [26:0] obsA, obsB;
  assign obsA = {busA.IorD, busA.MemRead, busA.MemWrite, busA.IRwrite, busA.RegWrite,
                 busA.ALUsrcA, busA.PCwrite, busA.PCwriteCond, busA.BranchNe, busA.ExtOp,
                 busA.RegDst, busA.MemtoReg, busA.ALUsrcB, busA.ALUop, busA.PCsource,
                 busA.instr_done, busA.illegal, busA.state_o};
  assign obsB = {busB.IorD, busB.MemRead, busB.MemWrite, busB.IRwrite, busB.RegWrite,
                 busB.ALUsrcA, busB.PCwrite, busB.PCwriteCond, busB.BranchNe, busB.ExtOp,
                 busB.RegDst, busB.MemtoReg, busB.ALUsrcB, busB.ALUop, busB.PCsource,
                 busB.instr_done, busB.illegal, busB.state_o};

  localparam logic [26:0] EIorD     = 27'd1 << 26;
  localparam logic [26:0] EMemRead  = 27'd1 << 25;
  localparam logic [26:0] EMemWrite = 27'd1 << 24;
  localparam logic [26:0] EIrWrite  = 27'd1 << 23;
  localparam logic [26:0] ERegWrite = 27'd1 << 22;
  localparam logic [26:0] ESrcA     = 27'd1 << 21;
  localparam logic [26:0] EPcWrite  = 27'd1 << 20;
  localparam logic [26:0] EPcWrCond = 27'd1 << 19;
  localparam logic [26:0] EBrNe     = 27'd1 << 18;
  localparam logic [26:0] EExtOp    = 27'd1 << 17;
  localparam logic [26:0] EDstRd    = 27'd1 << 15;
  localparam logic [26:0] EDst31    = 27'd2 << 15;
  localparam logic [26:0] EMtrMdr   = 27'd1 << 13;
  localparam logic [26:0] EMtrPc    = 27'd2 << 13;
  localparam logic [26:0] EB4       = 27'd1 << 11;
  localparam logic [26:0] EBImm     = 27'd2 << 11;
  localparam logic [26:0] EBImm2    = 27'd3 << 11;
  localparam logic [26:0] EAluSub   = 27'd1 << 8;
  localparam logic [26:0] EAluFn    = 27'd2 << 8;
  localparam logic [26:0] EAluAnd   = 27'd3 << 8;
  localparam logic [26:0] EAluOr    = 27'd4 << 8;
  localparam logic [26:0] EAluSlt   = 27'd5 << 8;
  localparam logic [26:0] EPcsOut   = 27'd1 << 6;
  localparam logic [26:0] EPcsJ     = 27'd2 << 6;
  localparam logic [26:0] EPcsA     = 27'd3 << 6;
  localparam logic [26:0] EDone     = 27'd1 << 5;
  localparam logic [26:0] EIll      = 27'd1 << 4;

  localparam logic [26:0] F1   = EMemRead | EIrWrite | EPcWrite | EB4;
  localparam logic [26:0] F0   = EMemRead | EB4;
  localparam logic [26:0] Dec  = EBImm2 | EExtOp | 27'd1;
  localparam logic [26:0] Addr = ESrcA | EBImm | EExtOp | 27'd2;
  localparam logic [26:0] Trap = EIll | 27'd15;
  localparam logic [26:0] IWb  = ERegWrite | EDone | 27'd11;

  localparam logic [31:0] LW   = 32'h8C22_0004;
  localparam logic [31:0] SW   = 32'hAC22_0008;
  localparam logic [31:0] BEQ  = 32'h1022_0003;
  localparam logic [31:0] BNE  = 32'h1422_0003;
  localparam logic [31:0] JMP  = 32'h0800_0010;
  localparam logic [31:0] JAL  = 32'h0C00_0010;
  localparam logic [31:0] JR   = 32'h03E0_0008;
  localparam logic [31:0] ADD  = 32'h0022_1820;
  localparam logic [31:0] ADDI = 32'h2022_FFFF;
  localparam logic [31:0] SLTI = 32'h2822_0005;
  localparam logic [31:0] ANDI = 32'h3022_00FF;
  localparam logic [31:0] ORI  = 32'h3422_8000;
  localparam logic [31:0] ILL  = 32'hFC00_0000;

  typedef struct {
    bit          which;
    logic [31:0] instr;
    logic        rdy;
    logic [26:0] exp;
  } vec_t;

  typedef struct {
    bit          which;
    int          idx;
    logic [26:0] exp;
  } sb_t;

  vec_t tab[$];
  sb_t  sbq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input bit w, input logic [31:0] i, input logic r, input logic [26:0] e);
    tab.push_back('{which: w, instr: i, rdy: r, exp: e});
  endtask

  task automatic checkNow(input string name, input logic [26:0] got, input logic [26:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One cycle per vector: drive after the edge, queue the expectation, compare at negedge.
  task automatic applyVec(input vec_t v, input int idx);
    sb_t e;
    if (v.which) begin
      busB.Instruction = v.instr;
      busB.mem_ready   = v.rdy;
    end else begin
      busA.Instruction = v.instr;
      busA.mem_ready   = v.rdy;
    end
    sbq.push_back('{which: v.which, idx: idx, exp: v.exp});
    @(negedge clk);
    e = sbq.pop_front();
    checkNow($sformatf("vec%0d dut%s", e.idx, e.which ? "B" : "A"),
             e.which ? obsB : obsA, e.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic runTable();
    for (int i = 0; i < tab.size(); i++) applyVec(tab[i], i);
    tab.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    busA.Instruction = '0;
    busA.mem_ready   = 1'b0;
    busB.Instruction = '0;
    busB.mem_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkNow("resetA", obsA, '0);
    checkNow("resetB", obsB, '0);
    rst_n = 1'b1;

    // Handshake/halting instance: every instruction class plus wait states.
    add(0, LW, 1, F1); add(0, LW, 1, Dec); add(0, LW, 1, Addr);
    add(0, LW, 1, EMemRead | EIorD | 27'd3);
    add(0, LW, 1, ERegWrite | EMtrMdr | EDone | 27'd4);
    add(0, BNE, 1, F1); add(0, BNE, 0, Dec);
    add(0, BNE, 1, ESrcA | EAluSub | EPcsOut | EPcWrCond | EBrNe | EDone | 27'd8);
    add(0, BEQ, 1, F1); add(0, BEQ, 1, Dec);
    add(0, BEQ, 0, ESrcA | EAluSub | EPcsOut | EPcWrCond | EDone | 27'd8);
    add(0, JMP, 1, F1); add(0, JMP, 1, Dec); add(0, JMP, 1, EPcsJ | EPcWrite | EDone | 27'd9);
    add(0, JAL, 1, F1); add(0, JAL, 1, Dec);
    add(0, JAL, 1, EPcsJ | EPcWrite | ERegWrite | EDst31 | EMtrPc | EDone | 27'd12);
    add(0, JR, 1, F1); add(0, JR, 1, Dec); add(0, JR, 1, EPcsA | EPcWrite | EDone | 27'd13);
    add(0, ADD, 1, F1); add(0, ADD, 1, Dec); add(0, ADD, 1, ESrcA | EAluFn | 27'd6);
    add(0, ADD, 1, ERegWrite | EDstRd | EDone | 27'd7);
    add(0, ORI, 1, F1); add(0, ORI, 1, Dec); add(0, ORI, 1, ESrcA | EBImm | EAluOr | 27'd10);
    add(0, ORI, 1, IWb);
    add(0, ADDI, 1, F1); add(0, ADDI, 1, Dec);
    add(0, ADDI, 1, ESrcA | EBImm | EExtOp | 27'd10); add(0, ADDI, 1, IWb);
    add(0, SLTI, 1, F1); add(0, SLTI, 1, Dec);
    add(0, SLTI, 1, ESrcA | EBImm | EExtOp | EAluSlt | 27'd10); add(0, SLTI, 1, IWb);
    add(0, ANDI, 1, F1); add(0, ANDI, 1, Dec);
    add(0, ANDI, 1, ESrcA | EBImm | EAluAnd | 27'd10); add(0, ANDI, 1, IWb);
    // sw with three wait cycles in FETCH and in MEM_WR: ten cycles total.
    add(0, SW, 0, F0); add(0, SW, 0, F0); add(0, SW, 0, F0); add(0, SW, 1, F1);
    add(0, SW, 1, Dec); add(0, SW, 1, Addr);
    add(0, SW, 0, EIorD | 27'd5); add(0, SW, 0, EIorD | 27'd5); add(0, SW, 0, EIorD | 27'd5);
    add(0, SW, 1, EMemWrite | EIorD | EDone | 27'd5);
    add(0, LW, 1, F1); add(0, LW, 1, Dec); add(0, LW, 1, Addr);
    add(0, LW, 0, EMemRead | EIorD | 27'd3); add(0, LW, 1, EMemRead | EIorD | 27'd3);
    add(0, LW, 0, ERegWrite | EMtrMdr | EDone | 27'd4);
    add(0, ILL, 1, F1); add(0, ILL, 1, Dec);
    add(0, ILL, 1, Trap); add(0, ILL, 0, Trap); add(0, ILL, 1, Trap);
    runTable();

    // Reset mid-TRAP: outputs drop immediately, then fetching resumes.
    rst_n = 1'b0;
    #1;
    checkNow("trapRstA", obsA, '0);
    @(posedge clk);
    #1;
    checkNow("trapRstHeldA", obsA, '0);
    rst_n = 1'b1;
    add(0, ILL, 1, F1); add(0, ILL, 1, Dec); add(0, ILL, 1, Trap);
    runTable();

    // Second instance starts from a fresh reset; mem_ready is mostly held low and ignored.
    rst_n = 1'b0;
    #1;
    checkNow("rstB", obsB, '0);
    rst_n = 1'b1;
    add(1, LW, 0, F1); add(1, LW, 0, Dec); add(1, LW, 0, Addr);
    add(1, LW, 0, EMemRead | EIorD | 27'd3);
    add(1, LW, 0, ERegWrite | EMtrMdr | EDone | 27'd4);
    add(1, SW, 0, F1); add(1, SW, 0, Dec); add(1, SW, 0, Addr);
    add(1, SW, 0, EMemWrite | EIorD | EDone | 27'd5);
    add(1, ILL, 0, F1); add(1, ILL, 0, Dec); add(1, ILL, 0, Trap);
    add(1, BNE, 1, F1); add(1, BNE, 1, Dec);
    add(1, BNE, 1, ESrcA | EAluSub | EPcsOut | EPcWrCond | EBrNe | EDone | 27'd8);
    add(1, ADD, 0, F1);
    runTable();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle MIPS control unit. It drives the datapath mux selects and write enables from a Moore state machine. The instruction set covers R-type, lw, sw, beq, bne, j, jal, jr, addi, slti, andi and ori. Optional memory wait-state handshake and a trap on illegal opcodes. Sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface
- MEM_HANDSHAKE, 1: 1 = FETCH/MEM_RD/MEM_WR hold until mem_ready; 0 = mem_ready ignored, single-cycle memory.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode parks in TRAP until reset; 0 = pulse illegal and return to FETCH.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Instruction  in  32  current IR contents; op=[31:26], funct=[5:0].
- mem_ready  in  1  memory access completes this cycle.
- IorD, MemRead, MemWrite, IRwrite, RegWrite, ALUsrcA, PCwrite, PCwriteCond  out  1 each  as named.
- BranchNe  out  1  0 = PCwriteCond on Zero, 1 = on !Zero.
- ExtOp  out  1  1 = sign-extend imm, 0 = zero-extend.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- ALUsrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- PCsource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A.
- instr_done  out  1  high in the final state of each instruction.
- illegal  out  1  high in TRAP, or the cycle after DECODE detects an illegal op.
- state_o  out  4  current state, for debug.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JAL 12, JR 13, TRAP 15.
- Outputs are a combinational decode of the state register, with no one-cycle lag. Any signal not listed for a state is 0.
- FETCH: MemRead, ALUsrcB=01. IRwrite and PCwrite are gated by mem_ready when MEM_HANDSHAKE=1. Next state is DECODE on ready, otherwise stay.
- DECODE: ALUsrcB=11, ExtOp=1. Next state by op:
  - 000000 with funct 001000 → JR; other 000000 → R_EXEC.
  - 100011/101011 → MEM_ADDR.
  - 000100/000101 → BRANCH.
  - 000010 → JUMP; 000011 → JAL.
  - 001000/001010/001100/001101 → I_EXEC.
  - Anything else → TRAP.
- MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ExtOp=1. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: MemRead, IorD. Next MEM_WB on ready.
- MEM_WB: RegWrite, MemtoReg=01.
- MEM_WR: MemWrite, IorD. Next FETCH on ready.
- R_EXEC: ALUsrcA=1, ALUop=010. R_WB: RegWrite, RegDst=01.
- BRANCH: ALUsrcA=1, ALUop=001, PCsource=01, PCwriteCond. BranchNe = op[0].
- JUMP: PCsource=10, PCwrite.
- JAL: PCsource=10, PCwrite, RegWrite, RegDst=10, MemtoReg=10. This writes PC+4 to $31.
- JR: PCsource=11, PCwrite.
- I_EXEC: ALUsrcA=1, ALUsrcB=10.
  - ALUop by op: addi 000, slti 101, andi 011, ori 100.
  - ExtOp=1 for addi/slti, 0 for andi/ori.
- I_WB: RegWrite, RegDst=00.
- instr_done is high in MEM_WB, MEM_WR (ready-qualified), R_WB, BRANCH, JUMP, JAL, JR and I_WB. All of these return to FETCH.
- TRAP: illegal=1. With HALT_ON_ILLEGAL=1 it stays in TRAP; with 0 it goes to FETCH next cycle.
- Unused encodings (14) go to TRAP.

## Timing
- rst_n low: the state goes to FETCH immediately (asynchronous). All outputs are forced to 0 while rst_n=0, including MemRead and state_o = 0.
- First fetch occurs on the first rising edge after rst_n rises.
- Cycle counts with zero wait states:
  - R, sw, I-type: 4 cycles.
  - lw: 5 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
- Each wait cycle (mem_ready=0 in FETCH, MEM_RD or MEM_WR) adds exactly 1 cycle. No write enable is asserted on a wait cycle.
- mem_ready high in a non-memory state has no effect.
- With MEM_HANDSHAKE=0, mem_ready held 0 yields identical timing to mem_ready held 1.
- Instruction must be stable from the cycle after IRwrite until the next FETCH.
- Reset asserted mid-instruction aborts it with no further writes.

## Test plan
- After reset, run lw with mem_ready=1 → states 0,1,2,3,4,0. MEM_WB has RegWrite=1, MemtoReg=01. instr_done is high for exactly 1 cycle.
- bne (op 000101) → BRANCH shows PCwriteCond=1, BranchNe=1, ALUop=001. beq → BranchNe=0. Both take 3 cycles.
- jal → JAL shows RegDst=10, MemtoReg=10, PCsource=10, PCwrite=1. jr (funct 001000) → PCsource=11.
- ori → I_EXEC shows ExtOp=0, ALUop=100, ALUsrcB=10. addi → ExtOp=1, ALUop=000.
- MEM_HANDSHAKE=1, mem_ready low for 3 cycles in FETCH and in MEM_WR for sw → IRwrite/PCwrite/instr_done fire only on the ready cycle. Total 10 cycles.
- Op 111111 → TRAP with illegal=1 held. Assert rst_n=0 mid-TRAP → outputs 0 at once, then resume FETCH. With HALT_ON_ILLEGAL=0 → back to FETCH after 1 cycle.
